// File: rtl/syscall_input_unit.sv
// Read-side syscall responder: services read_int / read_string / read_char from a
// console byte stream, stalling the pipeline until the result is delivered.
module syscall_input_unit #(
  parameter logic [7:0]  NEWLINE  = 8'h0A,
  parameter int unsigned DEC_BASE = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        syscall_control,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        sysstall,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        wb_en,
  output logic [31:0] wb_data
);

  typedef enum logic [2:0] {
    IDLE, RD_INT, RD_CHAR, RD_STR, STR_TERM, WB, DONE
  } state_t;

  state_t             r_state;
  logic        [31:0] r_acc;
  logic        [31:0] r_cnt;
  logic        [31:0] r_a0;
  logic signed [31:0] r_a1;
  logic        [31:0] r_wb_data;
  logic               r_neg;
  logic               r_first;

  logic               w_svc_read;
  logic               w_is_digit;
  logic        [31:0] w_digit;
  logic               w_str_last;

  always_comb begin
    w_svc_read = (v0 == 32'd5) || (v0 == 32'd8) || (v0 == 32'd12);
    w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
    w_digit    = {24'b0, in_data - 8'h30};
    // The byte being accepted now would be the (n-1)th stored; the last slot is the NUL.
    w_str_last = (r_cnt + 32'd1) == (r_a1 - 32'sd1);
  end

  always_comb begin
    in_ready = (r_state == RD_INT) || (r_state == RD_CHAR) || (r_state == RD_STR);
    sysstall = ((r_state != IDLE) && (r_state != DONE)) ||
               ((r_state == IDLE) && syscall_control && w_svc_read);
    wb_en    = (r_state == WB);
    wb_data  = r_wb_data;
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    if ((r_state == RD_STR) && in_valid) begin
      mem_we    = 1'b1;
      mem_addr  = r_a0 + r_cnt;
      mem_wdata = in_data;
    end else if (r_state == STR_TERM) begin
      mem_we    = 1'b1;
      mem_addr  = r_a0 + r_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_acc     <= 32'd0;
      r_cnt     <= 32'd0;
      r_a0      <= 32'd0;
      r_a1      <= 32'sd0;
      r_wb_data <= 32'd0;
      r_neg     <= 1'b0;
      r_first   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (syscall_control && w_svc_read) begin
            r_acc   <= 32'd0;
            r_cnt   <= 32'd0;
            r_neg   <= 1'b0;
            r_first <= 1'b1;
            r_a0    <= a0;
            r_a1    <= $signed(a1);
            if (v0 == 32'd5)
              r_state <= RD_INT;
            else if (v0 == 32'd12)
              r_state <= RD_CHAR;
            else if ($signed(a1) <= 32'sd0)
              r_state <= DONE;
            else if (a1 == 32'd1)
              r_state <= STR_TERM;
            else
              r_state <= RD_STR;
          end
        end
        RD_INT: begin
          if (in_valid) begin
            r_first <= 1'b0;
            if (in_data == NEWLINE) begin
              r_wb_data <= r_neg ? (~r_acc + 32'd1) : r_acc;
              r_state   <= WB;
            end else if (w_is_digit) begin
              r_acc <= r_acc * DEC_BASE + w_digit;
            end else if ((in_data == 8'h2D) && r_first) begin
              r_neg <= 1'b1;
            end
          end
        end
        RD_CHAR: begin
          if (in_valid) begin
            r_wb_data <= {24'b0, in_data};
            r_state   <= WB;
          end
        end
        RD_STR: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 32'd1;
            if ((in_data == NEWLINE) || w_str_last)
              r_state <= STR_TERM;
          end
        end
        STR_TERM: r_state <= DONE;
        WB:       r_state <= DONE;
        // Hold here until the syscall instruction leaves so it is serviced once.
        DONE:     if (!syscall_control) r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_syscall_input_unit.sv
// Bench for syscall_input_unit: directed scenarios plus randomized syscalls
// checked against a string-level model of the read services.
module tb_syscall_input_unit;

  localparam logic [7:0] NL = 8'h0A;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        syscall_control;
  logic [31:0] v0, a0, a1;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready, sysstall, mem_we, wb_en;
  logic [31:0] mem_addr, wb_data;
  logic [7:0]  mem_wdata;

  syscall_input_unit dut (
    .clk(clk), .reset_n(reset_n), .syscall_control(syscall_control),
    .v0(v0), .a0(a0), .a1(a1), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sysstall(sysstall), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wb_en(wb_en), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  src_q[$];
  logic [31:0] obs_addr[$], exp_addr[$];
  logic [7:0]  obs_data[$], exp_data[$];
  int          n_consumed, n_wb, n_stall, wb_cyc, last_stall_cyc, extra_act, force_gap;
  logic [31:0] wb_val;
  int          exp_cons, exp_wb_n, exp_stall_one;
  logic [31:0] exp_wb_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) src_q.push_back(s[i]);
  endtask

  // Expected outcome computed from the service rules over the pending console bytes.
  task automatic model(input logic [31:0] v, input logic [31:0] a, input logic [31:0] n);
    int unsigned acc;
    bit          neg;
    int          i;
    exp_addr.delete(); exp_data.delete();
    exp_cons = 0; exp_wb_n = 0; exp_wb_val = wb_data; exp_stall_one = 0;
    if (v == 32'd5) begin
      acc = 0; neg = 0; i = 0;
      while (i < src_q.size()) begin
        i++;
        if (src_q[i-1] == NL) break;
        if (src_q[i-1] >= "0" && src_q[i-1] <= "9") acc = acc * 10 + (src_q[i-1] - 8'h30);
        else if (src_q[i-1] == "-" && i == 1) neg = 1;
      end
      exp_cons = i; exp_wb_n = 1;
      exp_wb_val = neg ? (32'd0 - acc) : acc;
    end else if (v == 32'd12) begin
      exp_cons = 1; exp_wb_n = 1; exp_wb_val = {24'b0, src_q[0]};
    end else if (v == 32'd8) begin
      if ($signed(n) <= 0) begin
        exp_stall_one = 1;
      end else begin
        i = 0;
        while (i < $signed(n) - 1) begin
          exp_addr.push_back(a + i); exp_data.push_back(src_q[i]);
          i++;
          if (src_q[i-1] == NL) break;
        end
        exp_addr.push_back(a + i); exp_data.push_back(8'h00);
        exp_cons = i;
      end
    end
  endtask

  task automatic service(input logic [31:0] v, input logic [31:0] a, input logic [31:0] n,
                         input int hold, input string tag);
    int cyc;
    bit done, is_read;
    is_read = (v == 5) || (v == 8) || (v == 12);
    model(v, a, n);
    obs_addr.delete(); obs_data.delete();
    n_consumed = 0; n_wb = 0; n_stall = 0; wb_cyc = -1; last_stall_cyc = -1; extra_act = 0;
    @(posedge clk); #1;
    syscall_control = 1'b1; v0 = v; a0 = a; a1 = n;
    cyc = 0; done = 0;
    while (!done) begin
      in_valid = (src_q.size() > 0) && (cyc >= force_gap) && ($urandom_range(0, 3) != 0);
      in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      @(negedge clk);
      if (sysstall) begin n_stall++; last_stall_cyc = cyc; end
      if (in_valid && in_ready) begin n_consumed++; void'(src_q.pop_front()); end
      if (mem_we) begin obs_addr.push_back(mem_addr); obs_data.push_back(mem_wdata); end
      if (wb_en) begin n_wb++; wb_val = wb_data; wb_cyc = cyc; end
      cyc++;
      if (!sysstall) done = 1;
      else if (cyc > 400) begin
        check({tag, "_timeout"}, 32'd1, 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    for (int h = 0; h < hold; h++) begin
      in_valid = (src_q.size() > 0);
      in_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
      @(negedge clk);
      if (sysstall || in_ready || wb_en || mem_we) extra_act++;
      @(posedge clk); #1;
    end
    syscall_control = 1'b0; in_valid = 1'b0;
    force_gap = 0;

    check({tag, "_consumed"}, n_consumed, exp_cons);
    check({tag, "_wb_count"}, n_wb, exp_wb_n);
    if (exp_wb_n == 1) begin
      check({tag, "_wb_data"}, wb_val, exp_wb_val);
      check({tag, "_wb_in_last_stall"}, wb_cyc, last_stall_cyc);
    end
    check({tag, "_stall_first"}, (n_stall > 0), is_read);
    if (exp_stall_one) check({tag, "_stall_len"}, n_stall, 1);
    check({tag, "_nwrites"}, obs_addr.size(), exp_addr.size());
    for (int k = 0; k < obs_addr.size() && k < exp_addr.size(); k++) begin
      check({tag, "_waddr"}, obs_addr[k], exp_addr[k]);
      check({tag, "_wdata"}, obs_data[k], exp_data[k]);
    end
    if (hold > 0) check({tag, "_hold_idle"}, extra_act, 0);
  endtask

  task automatic push_rand_line(input bit numeric);
    int len;
    logic [7:0] c;
    len = $urandom_range(0, 12);
    for (int i = 0; i < len; i++) begin
      if (numeric) begin
        case ($urandom_range(0, 9))
          0:       c = "-";
          1:       c = 8'h41 + $urandom_range(0, 25);
          default: c = 8'h30 + $urandom_range(0, 9);
        endcase
      end else begin
        c = 8'h20 + $urandom_range(0, 94);
      end
      src_q.push_back(c);
    end
    src_q.push_back(NL);
  endtask

  initial begin
    reset_n = 1'b0; syscall_control = 1'b0; v0 = 0; a0 = 0; a1 = 0;
    in_valid = 1'b0; in_data = 8'h00; force_gap = 0;
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_sysstall", sysstall, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_data", wb_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    push_str("-123\n");
    service(32'd5, 0, 0, 0, "int_neg");
    check("int_neg_const", wb_val, 32'hFFFFFF85);

    src_q.delete(); push_str("A");
    force_gap = 3;
    service(32'd12, 0, 0, 0, "char_gap");
    check("char_gap_const", wb_val, 32'h00000041);

    src_q.delete(); push_str("hello\n");
    service(32'd8, 32'h100, 32'd4, 0, "str_trunc");
    check("str_trunc_left", src_q.size(), 3);
    check("str_trunc_wb_hold", wb_data, 32'h00000041);

    src_q.delete(); push_str("hi\n");
    service(32'd8, 32'h200, 32'd8, 0, "str_nl");
    check("str_nl_n", obs_addr.size(), 4);
    service(32'd8, 32'h200, 32'd0, 2, "str_zero");

    push_str("xy\n");
    service(32'd8, 32'h300, 32'd1, 0, "str_one");

    service(32'd1, 0, 0, 3, "svc_print");
    service(32'd10, 0, 0, 3, "svc_exit");

    src_q.delete(); push_str("QR");
    service(32'd12, 0, 0, 5, "char_hold");
    check("char_hold_left", src_q.size(), 1);

    src_q.delete();
    @(posedge clk); #1;
    syscall_control = 1'b1; v0 = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = "1";
    @(posedge clk); #1;
    in_data = "2";
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_stall", sysstall, 1);
    check("mid_ready", in_ready, 1);
    #2; reset_n = 1'b0; syscall_control = 1'b0;
    #1;
    check("mid_rst_stall", sysstall, 0);
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_wb_data", wb_data, 0);
    @(negedge clk); reset_n = 1'b1;
    push_str("7\n");
    service(32'd5, 0, 0, 0, "int_after_rst");
    check("int_after_rst_const", wb_val, 32'd7);

    for (int t = 0; t < 30; t++) begin
      int sel;
      logic [31:0] n;
      if (src_q.size() > 60) src_q.delete();
      sel = $urandom_range(0, 3);
      push_rand_line(sel <= 1);
      case (sel)
        0, 1: service(32'd5, 0, 0, $urandom_range(0, 2), "rnd_int");
        2:    service(32'd12, 0, 0, $urandom_range(0, 2), "rnd_char");
        default: begin
          n = $urandom_range(0, 10) - 2;
          service(32'd8, $urandom, n, $urandom_range(0, 2), "rnd_str");
        end
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/syscall_input_unit.md
Name: syscall_input_unit

Overview:
Input-side syscall responder for the pipelined MIPS core. It services the read-type syscalls by consuming console bytes over a valid/ready stream:
- read_int (v0=5)
- read_string (v0=8)
- read_char (v0=12)

It stalls the pipeline while it works. It returns integer or char results to the v0 writeback port and writes string bytes into data memory. Output-type syscalls (print, exit) are ignored here.

Parameters:
NEWLINE, 8'h0A, input line terminator
DEC_BASE, 10, radix for read_int accumulation

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
syscall_control  input  1  decoded syscall instruction present
v0  input  32  syscall service code
a0  input  32  read_string buffer base address
a1  input  32  read_string buffer length n (signed)
in_valid  input  1  console byte available
in_data  input  8  console byte
in_ready  output  1  unit accepts in_data this cycle
sysstall  output  1  pipeline stall request
mem_we  output  1  byte write strobe to data memory
mem_addr  output  32  byte write address
mem_wdata  output  8  byte write data
wb_en  output  1  one-cycle pulse: write wb_data to register v0
wb_data  output  32  syscall return value

Behaviour:
- Clock and reset: single clock domain, rising edge. reset_n is asynchronous and active-low.
- Reset:
  - state=IDLE; accumulator, count and negative flag cleared; latched v0/a0/a1 cleared.
  - All outputs 0: in_ready, sysstall, mem_we, mem_addr, mem_wdata, wb_en, wb_data.
- States: IDLE, RD_INT, RD_CHAR, RD_STR, STR_TERM, WB, DONE.
- Transfer rule: a byte transfers only when in_valid && in_ready on a rising edge. in_ready=1 only in RD_INT, RD_CHAR and RD_STR.
- sysstall (combinational):
  - 1 when state ∉ {IDLE, DONE}.
  - 1 in IDLE when syscall_control=1 and v0 ∈ {5, 8, 12}.
  - 0 otherwise. The stall is therefore visible in the same cycle the syscall is presented.
- IDLE:
  - On syscall_control=1 with v0=5/12/8: latch v0, a0, a1; go to RD_INT/RD_CHAR/RD_STR respectively.
  - Any other v0: stay in IDLE, no stall.
  - v0=8 with signed a1 ≤ 0: go directly to DONE, no memory writes.
- RD_INT (per accepted byte):
  - '0'..'9': acc = acc*10 + digit, modulo 2^32 (wraps silently).
  - '-' as first accepted byte: set the negative flag.
  - NEWLINE: go to WB.
  - Any other byte: discarded.
  - Result = negative ? (~acc+1) : acc. A line with no digits returns 0.
- RD_CHAR: first accepted byte (any value, including NEWLINE) → wb_data = {24'b0, byte}; go to WB.
- RD_STR (per accepted byte):
  - Same cycle as the transfer: mem_we=1, mem_addr=a0+count, mem_wdata=byte; then count++.
  - Go to STR_TERM when the byte is NEWLINE (the newline is stored) or when count+1 == n-1.
  - n=1: enter STR_TERM immediately, with no byte consumed.
- STR_TERM: one cycle with mem_we=1, mem_addr=a0+count, mem_wdata=0; then go to DONE. read_string produces no wb_en.
- WB: wb_en=1 for exactly one cycle with wb_data valid, sysstall still 1; then go to DONE. wb_data holds its value until the next WB.
- DONE: sysstall=0; return to IDLE once syscall_control=0. This prevents one syscall instruction from being serviced twice.
- Backpressure: in_valid gaps simply extend the current read state; no timeout.
- Reset mid-operation: immediate return to IDLE, stall released, no writeback. Bytes already written to memory remain.
- Unconsumed input bytes (e.g. the tail of a truncated read_string) stay in the source for the next read syscall.

Test Plan:
- read_int: v0=5, stream "-123\n" → in_ready high for 5 transfers; one wb_en pulse with wb_data=32'hFFFFFF85; sysstall=1 from the syscall cycle through the WB cycle, then 0.
- read_char: v0=12, stream 'A' with in_valid low for 3 cycles first → stall persists through the gap; wb_en once with wb_data=32'h00000041; exactly one byte consumed.
- read_string truncation: v0=8, a0=0x100, a1=4, stream "hello\n" → writes 'h','e','l' at 0x100–0x102 and 0x00 at 0x103; no wb_en; 'l','o','\n' not consumed.
- read_string newline: a0=0x200, a1=8, stream "hi\n" → writes 'h','i',0x0A,0x00 at 0x200–0x203. Then a1=0 → no stall beyond the syscall cycle, no writes.
- Non-read services and re-trigger: v0=1 or v0=10 → sysstall stays 0, no activity. syscall_control held high after a read_char completes → no second service until it drops.
- Reset mid-op: assert reset_n=0 during RD_INT after "12" → outputs all 0 asynchronously, state IDLE. A following read_int "7\n" returns 7.
